// File: rtl/tx_ts_fp_tracker.sv
// Pairs fingerprinted MAC egress timestamps with in-order TX timestamp requests and
// retires every request as exactly one record (ok / missing / timeout); output registered, no backpressure.
module tx_ts_fp_tracker #(
    parameter int TS_FP_WIDTH     = 20,
    parameter int TS_WIDTH        = 96,
    parameter int PEND_ADDR_WIDTH = 5,
    parameter int IN_ADDR_WIDTH   = 2,
    parameter int AGE_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                   ts_resp_clk,
    input  logic                   ts_resp_rst,
    input  logic                   in_req_valid,
    input  logic [TS_FP_WIDTH-1:0] in_req_fp,
    input  logic                   in_mac_ts_valid,
    input  logic [TS_FP_WIDTH-1:0] in_mac_ts_fp,
    input  logic [TS_WIDTH-1:0]    in_mac_ts_data,
    output logic                   out_ts_valid,
    output logic [TS_FP_WIDTH-1:0] out_ts_fp,
    output logic [TS_WIDTH-1:0]    out_ts_data,
    output logic [1:0]             out_ts_err,
    input  logic                   clear_cnt,
    output logic [15:0]            cnt_missing,
    output logic [15:0]            cnt_timeout,
    output logic [15:0]            cnt_stray,
    output logic                   req_overflow,
    output logic                   in_overflow
);
    localparam int PEND_DEPTH = 1 << PEND_ADDR_WIDTH;
    localparam int IN_DEPTH   = 1 << IN_ADDR_WIDTH;
    localparam logic [AGE_WIDTH-1:0] TIMEOUT_AGE = AGE_WIDTH'(TIMEOUT_CYCLES);

    logic [TS_FP_WIDTH-1:0]   r_pend_fp    [PEND_DEPTH];
    logic [AGE_WIDTH-1:0]     r_pend_stamp [PEND_DEPTH];
    logic [PEND_ADDR_WIDTH-1:0] r_pend_wr, r_pend_rd;
    logic [PEND_ADDR_WIDTH:0]   r_pend_cnt;

    logic [TS_FP_WIDTH-1:0]   r_in_fp   [IN_DEPTH];
    logic [TS_WIDTH-1:0]      r_in_data [IN_DEPTH];
    logic [IN_ADDR_WIDTH-1:0] r_in_wr, r_in_rd;
    logic [IN_ADDR_WIDTH:0]   r_in_cnt;

    logic [AGE_WIDTH-1:0]   r_age;
    logic                   r_out_vld;
    logic [TS_FP_WIDTH-1:0] r_out_fp;
    logic [TS_WIDTH-1:0]    r_out_data;
    logic [1:0]             r_out_err;
    logic [15:0]            r_cnt_missing, r_cnt_timeout, r_cnt_stray;
    logic                   r_req_ovf, r_in_ovf;

    logic w_pend_full, w_pend_empty, w_in_full, w_in_empty, w_pend_push, w_in_push;
    logic [TS_FP_WIDTH-1:0] w_h_fp, w_p_fp, w_dist;
    logic [TS_WIDTH-1:0]    w_h_data;
    logic [AGE_WIDTH-1:0]   w_age_diff;
    logic                   w_pop_h, w_pop_p, w_emit, w_inc_missing, w_inc_timeout, w_inc_stray;
    logic [TS_WIDTH-1:0]    w_emit_data;
    logic [1:0]             w_emit_err;

    // Fullness is judged on current occupancy, so a same-cycle pop never rescues a push.
    assign w_pend_full  = (r_pend_cnt == (PEND_ADDR_WIDTH+1)'(PEND_DEPTH));
    assign w_pend_empty = (r_pend_cnt == '0);
    assign w_in_full    = (r_in_cnt == (IN_ADDR_WIDTH+1)'(IN_DEPTH));
    assign w_in_empty   = (r_in_cnt == '0);
    assign w_pend_push  = in_req_valid && !w_pend_full;
    assign w_in_push    = in_mac_ts_valid && !w_in_full;

    assign w_h_fp     = r_in_fp[r_in_rd];
    assign w_h_data   = r_in_data[r_in_rd];
    assign w_p_fp     = r_pend_fp[r_pend_rd];
    assign w_dist     = w_h_fp - w_p_fp;
    assign w_age_diff = r_age - r_pend_stamp[r_pend_rd];

    always_comb begin
        w_pop_h       = 1'b0;
        w_pop_p       = 1'b0;
        w_emit        = 1'b0;
        w_emit_data   = '0;
        w_emit_err    = 2'b00;
        w_inc_missing = 1'b0;
        w_inc_timeout = 1'b0;
        w_inc_stray   = 1'b0;
        if (!w_in_empty) begin
            if (w_pend_empty) begin
                w_pop_h     = 1'b1;
                w_inc_stray = 1'b1;
            end else if (w_dist == '0) begin
                w_emit      = 1'b1;
                w_emit_data = w_h_data;
                w_pop_h     = 1'b1;
                w_pop_p     = 1'b1;
            end else if (w_dist < TS_FP_WIDTH'(r_pend_cnt)) begin
                // Timestamp belongs to a younger request: retire the head as missing, keep H.
                w_emit        = 1'b1;
                w_emit_err    = 2'b01;
                w_pop_p       = 1'b1;
                w_inc_missing = 1'b1;
            end else begin
                w_pop_h     = 1'b1;
                w_inc_stray = 1'b1;
            end
        end else if (!w_pend_empty && (w_age_diff >= TIMEOUT_AGE)) begin
            w_emit        = 1'b1;
            w_emit_err    = 2'b10;
            w_pop_p       = 1'b1;
            w_inc_timeout = 1'b1;
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge ts_resp_clk) begin
        if (w_pend_push) begin
            r_pend_fp[r_pend_wr]    <= in_req_fp;
            r_pend_stamp[r_pend_wr] <= r_age;
        end
        if (w_in_push) begin
            r_in_fp[r_in_wr]   <= in_mac_ts_fp;
            r_in_data[r_in_wr] <= in_mac_ts_data;
        end
    end

    always_ff @(posedge ts_resp_clk) begin
        if (ts_resp_rst) begin
            r_pend_wr <= '0; r_pend_rd <= '0; r_pend_cnt <= '0;
            r_in_wr   <= '0; r_in_rd   <= '0; r_in_cnt   <= '0;
            r_age      <= '0;
            r_out_vld  <= 1'b0;
            r_out_fp   <= '0;
            r_out_data <= '0;
            r_out_err  <= 2'b00;
            r_cnt_missing <= '0; r_cnt_timeout <= '0; r_cnt_stray <= '0;
            r_req_ovf <= 1'b0;
            r_in_ovf  <= 1'b0;
        end else begin
            r_age <= r_age + AGE_WIDTH'(1);
            if (w_pend_push) r_pend_wr <= r_pend_wr + PEND_ADDR_WIDTH'(1);
            if (w_pop_p)     r_pend_rd <= r_pend_rd + PEND_ADDR_WIDTH'(1);
            case ({w_pend_push, w_pop_p})
                2'b10:   r_pend_cnt <= r_pend_cnt + (PEND_ADDR_WIDTH+1)'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - (PEND_ADDR_WIDTH+1)'(1);
                default: ;
            endcase
            if (w_in_push) r_in_wr <= r_in_wr + IN_ADDR_WIDTH'(1);
            if (w_pop_h)   r_in_rd <= r_in_rd + IN_ADDR_WIDTH'(1);
            case ({w_in_push, w_pop_h})
                2'b10:   r_in_cnt <= r_in_cnt + (IN_ADDR_WIDTH+1)'(1);
                2'b01:   r_in_cnt <= r_in_cnt - (IN_ADDR_WIDTH+1)'(1);
                default: ;
            endcase
            r_out_vld  <= w_emit;
            r_out_fp   <= w_emit ? w_p_fp : '0;
            r_out_data <= w_emit_data;
            r_out_err  <= w_emit_err;
            if (clear_cnt) begin
                r_cnt_missing <= '0; r_cnt_timeout <= '0; r_cnt_stray <= '0;
                r_req_ovf <= 1'b0;
                r_in_ovf  <= 1'b0;
            end else begin
                if (w_inc_missing) r_cnt_missing <= sat_inc(r_cnt_missing);
                if (w_inc_timeout) r_cnt_timeout <= sat_inc(r_cnt_timeout);
                if (w_inc_stray)   r_cnt_stray   <= sat_inc(r_cnt_stray);
                if (in_req_valid && w_pend_full)  r_req_ovf <= 1'b1;
                if (in_mac_ts_valid && w_in_full) r_in_ovf  <= 1'b1;
            end
        end
    end

    assign out_ts_valid = r_out_vld;
    assign out_ts_fp    = r_out_fp;
    assign out_ts_data  = r_out_data;
    assign out_ts_err   = r_out_err;
    assign cnt_missing  = r_cnt_missing;
    assign cnt_timeout  = r_cnt_timeout;
    assign cnt_stray    = r_cnt_stray;
    assign req_overflow = r_req_ovf;
    assign in_overflow  = r_in_ovf;
endmodule

// File: tb/tb_tx_ts_fp_tracker.sv
// Bench for tx_ts_fp_tracker: per-cycle vector table plus hand-built corner sequences,
// records checked (content and arrival cycle) against a scoreboard queue.
module tb_tx_ts_fp_tracker;
    localparam int FPW = 20;
    localparam int TSW = 96;
    localparam int TO  = 64;

    logic           ts_resp_clk = 1'b0;
    logic           ts_resp_rst;
    logic           in_req_valid;
    logic [FPW-1:0] in_req_fp;
    logic           in_mac_ts_valid;
    logic [FPW-1:0] in_mac_ts_fp;
    logic [TSW-1:0] in_mac_ts_data;
    logic           out_ts_valid;
    logic [FPW-1:0] out_ts_fp;
    logic [TSW-1:0] out_ts_data;
    logic [1:0]     out_ts_err;
    logic           clear_cnt;
    logic [15:0]    cnt_missing, cnt_timeout, cnt_stray;
    logic           req_overflow, in_overflow;

    tx_ts_fp_tracker #(
        .TS_FP_WIDTH(FPW), .TS_WIDTH(TSW), .PEND_ADDR_WIDTH(5), .IN_ADDR_WIDTH(2),
        .AGE_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ts_resp_clk(ts_resp_clk), .ts_resp_rst(ts_resp_rst),
        .in_req_valid(in_req_valid), .in_req_fp(in_req_fp),
        .in_mac_ts_valid(in_mac_ts_valid), .in_mac_ts_fp(in_mac_ts_fp),
        .in_mac_ts_data(in_mac_ts_data),
        .out_ts_valid(out_ts_valid), .out_ts_fp(out_ts_fp), .out_ts_data(out_ts_data),
        .out_ts_err(out_ts_err), .clear_cnt(clear_cnt),
        .cnt_missing(cnt_missing), .cnt_timeout(cnt_timeout), .cnt_stray(cnt_stray),
        .req_overflow(req_overflow), .in_overflow(in_overflow)
    );

    always #5 ts_resp_clk = ~ts_resp_clk;

    typedef struct {
        logic           req_v;
        logic [FPW-1:0] req_fp;
        logic           mac_v;
        logic [FPW-1:0] mac_fp;
        logic [TSW-1:0] mac_data;
        logic           exp_v;
        logic [FPW-1:0] exp_fp;
        logic [TSW-1:0] exp_data;
        logic [1:0]     exp_err;
    } vec_t;

    typedef struct {
        logic [FPW-1:0] fp;
        logic [TSW-1:0] data;
        logic [1:0]     err;
        int             cyc;
    } rec_t;

    vec_t vt [32];
    rec_t sb [$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge ts_resp_clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic rv, input logic [FPW-1:0] rfp,
                                input logic mv, input logic [FPW-1:0] mfp, input logic [TSW-1:0] md,
                                input logic ev, input logic [FPW-1:0] efp, input logic [TSW-1:0] ed,
                                input logic [1:0] ee);
        vec_t v;
        v.req_v = rv; v.req_fp = rfp; v.mac_v = mv; v.mac_fp = mfp; v.mac_data = md;
        v.exp_v = ev; v.exp_fp = efp; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge ts_resp_clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_req_valid = 1'b0; in_req_fp = '0;
        in_mac_ts_valid = 1'b0; in_mac_ts_fp = '0; in_mac_ts_data = '0;
        clear_cnt = 1'b0;
    endtask

    task automatic chk(input string name, input logic [TSW-1:0] act, input logic [TSW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        chk(name, TSW'(act), TSW'(exp));
    endtask

    task automatic chk_cnts(input string tag, input logic [15:0] m, input logic [15:0] t,
                            input logic [15:0] s);
        chk16({tag, "_missing"}, cnt_missing, m);
        chk16({tag, "_timeout"}, cnt_timeout, t);
        chk16({tag, "_stray"},   cnt_stray,   s);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            in_req_valid    = vt[i].req_v;
            in_req_fp       = vt[i].req_fp;
            in_mac_ts_valid = vt[i].mac_v;
            in_mac_ts_fp    = vt[i].mac_fp;
            in_mac_ts_data  = vt[i].mac_data;
            if (vt[i].exp_v) sb.push_back('{vt[i].exp_fp, vt[i].exp_data, vt[i].exp_err, cyc + 2});
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int m;
        // in-order match
        vt[0]  = mk(1'b1, 20'd5, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[1]  = mk(1'b1, 20'd6, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[2]  = mk(1'b1, 20'd7, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[3]  = mk(1'b0, 20'd0, 1'b1, 20'd5, 96'hA, 1'b1, 20'd5, 96'hA, 2'b00);
        vt[4]  = mk(1'b0, 20'd0, 1'b1, 20'd6, 96'hB, 1'b1, 20'd6, 96'hB, 2'b00);
        vt[5]  = mk(1'b0, 20'd0, 1'b1, 20'd7, 96'hC, 1'b1, 20'd7, 96'hC, 2'b00);
        vt[6]  = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[7]  = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        // missing: only the third timestamp returns
        vt[8]  = mk(1'b1, 20'd10, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[9]  = mk(1'b1, 20'd11, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[10] = mk(1'b1, 20'd12, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[11] = mk(1'b0, 20'd0, 1'b1, 20'd12, 96'hD, 1'b1, 20'd10, 96'h0, 2'b01);
        vt[12] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b1, 20'd11, 96'h0, 2'b01);
        vt[13] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b1, 20'd12, 96'hD, 2'b00);
        vt[14] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[15] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        // stray with nothing pending
        vt[16] = mk(1'b0, 20'd0, 1'b1, 20'd9, 96'h99, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[17] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[18] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        // fingerprint wrap: straight matches, then a missing across the wrap
        vt[19] = mk(1'b1, 20'hFFFFF, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[20] = mk(1'b1, 20'h00000, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[21] = mk(1'b0, 20'd0, 1'b1, 20'hFFFFF, 96'h1, 1'b1, 20'hFFFFF, 96'h1, 2'b00);
        vt[22] = mk(1'b0, 20'd0, 1'b1, 20'h00000, 96'h2, 1'b1, 20'h00000, 96'h2, 2'b00);
        vt[23] = mk(1'b1, 20'hFFFFF, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[24] = mk(1'b1, 20'h00000, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[25] = mk(1'b0, 20'd0, 1'b1, 20'h00000, 96'h3, 1'b1, 20'hFFFFF, 96'h0, 2'b01);
        vt[26] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b1, 20'h00000, 96'h3, 2'b00);
        // stale timestamp (one behind head) is dropped, then the real one matches
        vt[27] = mk(1'b1, 20'd20, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[28] = mk(1'b0, 20'd0, 1'b1, 20'd19, 96'h5, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[29] = mk(1'b0, 20'd0, 1'b1, 20'd20, 96'h6, 1'b1, 20'd20, 96'h6, 2'b00);
        vt[30] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);
        vt[31] = mk(1'b0, 20'd0, 1'b0, 20'd0, 96'h0, 1'b0, 20'd0, 96'h0, 2'b00);

        idle_inputs();
        ts_resp_rst = 1'b1;

        fork
            forever begin
                rec_t e;
                @(negedge ts_resp_clk);
                if (out_ts_valid) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_record: got fp=%0h err=%0d data=%0h at cycle %0d, want none",
                                 out_ts_fp, out_ts_err, out_ts_data, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (out_ts_fp !== e.fp || out_ts_data !== e.data || out_ts_err !== e.err || cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL record: got fp=%0h data=%0h err=%0d cyc=%0d, want fp=%0h data=%0h err=%0d cyc=%0d",
                                     out_ts_fp, out_ts_data, out_ts_err, cyc, e.fp, e.data, e.err, e.cyc);
                        end
                    end
                end
            end
        join_none

        repeat (3) step();
        chk("rst_valid", TSW'(out_ts_valid), '0);
        chk("rst_data", out_ts_data, '0);
        chk("rst_flags", TSW'({req_overflow, in_overflow}), '0);
        chk_cnts("rst", 16'd0, 16'd0, 16'd0);
        ts_resp_rst = 1'b0;

        run_rows(0, 7);
        chk_cnts("inorder", 16'd0, 16'd0, 16'd0);
        run_rows(8, 15);
        chk16("miss_missing", cnt_missing, 16'd2);
        run_rows(16, 18);
        chk16("stray_empty", cnt_stray, 16'd1);
        run_rows(19, 31);
        chk_cnts("wrap", 16'd3, 16'd0, 16'd2);

        // Input FIFO overflow: a far-ahead timestamp blocks while older requests retire as missing.
        for (int i = 0; i < 8; i++) begin
            in_req_valid = 1'b1; in_req_fp = FPW'(40 + i);
            step();
        end
        in_req_valid = 1'b0;
        m = cyc;
        for (int k = 0; k < 7; k++) sb.push_back('{FPW'(40 + k), '0, 2'b01, m + 2 + k});
        sb.push_back('{20'd47, 96'h100, 2'b00, m + 9});
        for (int j = 0; j < 6; j++) begin
            in_mac_ts_valid = 1'b1; in_mac_ts_fp = 20'd47; in_mac_ts_data = TSW'(256 + j);
            step();
        end
        idle_inputs();
        repeat (10) step();
        chk_cnts("inovf", 16'd10, 16'd0, 16'd5);
        chk("inovf_flag", TSW'(in_overflow), TSW'(1'b1));
        chk("inovf_reqflag", TSW'(req_overflow), '0);

        // Timeout: record lands TO cycles after the push plus the output register.
        in_req_valid = 1'b1; in_req_fp = 20'd3;
        sb.push_back('{20'd3, '0, 2'b10, cyc + TO + 1});
        step();
        idle_inputs();
        repeat (TO + 4) step();
        chk16("timeout_cnt", cnt_timeout, 16'd1);

        // Pending overflow, then clear.
        for (int i = 0; i < 33; i++) begin
            in_req_valid = 1'b1; in_req_fp = FPW'(100 + i);
            step();
        end
        idle_inputs();
        step();
        chk("reqovf_flag", TSW'(req_overflow), TSW'(1'b1));
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        chk_cnts("clear", 16'd0, 16'd0, 16'd0);
        chk("clear_flags", TSW'({req_overflow, in_overflow}), '0);

        // Drain one (31 left), then push while popping: occupancy must stay 31.
        in_mac_ts_valid = 1'b1; in_mac_ts_fp = 20'd100; in_mac_ts_data = 96'h200;
        sb.push_back('{20'd100, 96'h200, 2'b00, cyc + 2});
        step();
        in_mac_ts_fp = 20'd101; in_mac_ts_data = 96'h201;
        sb.push_back('{20'd101, 96'h201, 2'b00, cyc + 2});
        step();
        idle_inputs();
        in_req_valid = 1'b1; in_req_fp = 20'd200;
        step();
        in_req_fp = 20'd201;
        step();
        idle_inputs();
        step();
        chk("simul_no_ovf", TSW'(req_overflow), '0);
        in_req_valid = 1'b1; in_req_fp = 20'd202;
        step();
        idle_inputs();
        step();
        chk("simul_full_ovf", TSW'(req_overflow), TSW'(1'b1));

        // Reset with a matching timestamp in flight: nothing may come out.
        in_mac_ts_valid = 1'b1; in_mac_ts_fp = 20'd102; in_mac_ts_data = 96'h300;
        step();
        idle_inputs();
        ts_resp_rst = 1'b1;
        step();
        chk("midrst_valid", TSW'(out_ts_valid), '0);
        chk("midrst_fp", TSW'(out_ts_fp), '0);
        chk("midrst_flags", TSW'({req_overflow, in_overflow}), '0);
        ts_resp_rst = 1'b0;

        run_rows(0, 7);
        chk_cnts("postrst", 16'd0, 16'd0, 16'd0);
        repeat (5) step();
        chk("sb_drain", TSW'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tx_ts_fp_tracker.md
Name: tx_ts_fp_tracker

Overview:
- Single-clock tracker on the TX timestamp return path.
- Records every TS request fingerprint issued at TX DMA packet start, in a pending FIFO.
- Matches fingerprinted egress timestamps returned by the MAC against the oldest pending request, in order.
- Emits one timestamp record per request (good, missing or timed-out) to the timestamp CDC FIFO write side, so the per-packet timestamp/response merge never slips alignment.

Parameters:
- TS_FP_WIDTH, 20, fingerprint width.
- TS_WIDTH, 96, timestamp data width.
- PEND_ADDR_WIDTH, 5, log2 of pending-request FIFO depth (32 entries).
- IN_ADDR_WIDTH, 2, log2 of MAC timestamp input FIFO depth (4 entries).
- AGE_WIDTH, 16, free-running age counter width.
- TIMEOUT_CYCLES, 4096, request age at which it is retired as timed-out; must be < 2^AGE_WIDTH.

Ports:
- ts_resp_clk  in  1  clock.
- ts_resp_rst  in  1  synchronous active-high reset.
- in_req_valid  in  1  TS request strobe (one per packet).
- in_req_fp  in  TS_FP_WIDTH  request fingerprint.
- in_mac_ts_valid  in  1  MAC egress timestamp strobe.
- in_mac_ts_fp  in  TS_FP_WIDTH  fingerprint echoed by MAC.
- in_mac_ts_data  in  TS_WIDTH  timestamp.
- out_ts_valid  out  1  record strobe (no backpressure).
- out_ts_fp  out  TS_FP_WIDTH  fingerprint of retired request.
- out_ts_data  out  TS_WIDTH  timestamp; 0 on error.
- out_ts_err  out  2  00 ok, 01 missing, 10 timeout.
- clear_cnt  in  1  pulse: zero all counters and the sticky flag.
- cnt_missing  out  16  saturating count of missing retirements.
- cnt_timeout  out  16  saturating count of timeout retirements.
- cnt_stray  out  16  saturating count of dropped unmatched MAC timestamps.
- req_overflow  out  1  sticky: request dropped because the pending FIFO was full.
- in_overflow  out  1  sticky: MAC timestamp dropped because the input FIFO was full.

Behaviour:
- Reset: all outputs 0, both FIFOs empty, age counter 0.
- Age counter: free-running, increments every cycle, wraps. Each pending entry stores {fp, stamp=age counter at push}.
- Request push: pushes when in_req_valid=1. If pending is full (evaluated before any pop that cycle), the request is dropped and req_overflow is set.
- MAC timestamp push: pushes into the input FIFO when in_mac_ts_valid=1. If the input FIFO is full, the timestamp is dropped and in_overflow is set.
- Push and pop of the same FIFO in the same cycle are legal; occupancy is unchanged.
- Resolve, once per cycle, in priority order. H = head of input FIFO, P = head of pending FIFO, cnt = pending occupancy, dist = (H.fp - P.fp) mod 2^TS_FP_WIDTH:
  - H valid, pending empty: pop H, cnt_stray++, no output.
  - H valid, dist==0: emit {P.fp, H.data, 00}; pop H and P.
  - H valid, 0<dist<cnt: emit {P.fp, 0, 01}; pop P only; H is retried next cycle. One missing record per cycle.
  - H valid, dist>=cnt: H is stale or unknown; pop H, cnt_stray++, no output.
  - H not valid, pending non-empty, (age counter - P.stamp) mod 2^AGE_WIDTH >= TIMEOUT_CYCLES: emit {P.fp, 0, 10}; pop P; cnt_timeout++.
  - Otherwise: no action.
- Missing records increment cnt_missing.
- Output registered:
  - Resolve decision in cycle N gives out_ts_valid=1 for exactly one cycle at N+1.
  - Best-case latency from in_mac_ts_valid to out_ts_valid is 2 cycles (input FIFO write, then resolve).
- A request pushed in cycle N is visible at the pending head no earlier than N+1.
- Counters saturate at 0xFFFF. clear_cnt takes priority over any increment in the same cycle.
- Fingerprint wrap: all comparisons are modulo 2^TS_FP_WIDTH (0xFFFFF→0x00000 is consecutive).
- Reset mid-operation flushes both FIFOs; no partial record is emitted after reset.

Test Plan:
1. In-order match: requests fp 5, 6, 7; MAC ts fp 5, 6, 7 with data 0xA, 0xB, 0xC → three records, err=00, data in order, 2-cycle latency each; all counters 0.
2. Missing: requests 10, 11, 12; MAC ts 12 only → records 10/01, 11/01, then 12/00 on consecutive cycles; cnt_missing=2.
3. Timeout: TIMEOUT_CYCLES=64; one request fp 3 with no MAC ts → single record fp 3, err=10, exactly 64 cycles (+1 output register) after the push; cnt_timeout=1.
4. Stray, then wrap: no pending requests, MAC ts fp 9 → no output, cnt_stray=1. Then requests 0xFFFFF, 0x00000 with matching MAC ts → two err=00 records.
5. Overflow: 33 back-to-back requests with PEND_ADDR_WIDTH=5 → req_overflow=1, 32 entries retained. Then clear_cnt → flag and counters return to 0.
6. Simultaneous: request push and matching pop in the same cycle while full-1 → no overflow, occupancy unchanged. Assert reset mid-stream → outputs 0 next cycle, subsequent in-order traffic matches cleanly.
